// File: rtl/hls_deadlock_monitor_unit.sv
// hls_deadlock_monitor_unit
//
// Per-process deadlock detection node. Merges incoming process-dependence
// vectors, forwards them (plus this process's own bit) on the outgoing
// dependence channels, and flags a deadlock when a dependence cycle leads
// back to this process for CONFIRM_CYCLES consecutive cycles. One report is
// latched per deadlock episode and held until acknowledged.
//
// Ports:
//   clock                 rising-edge clock
//   reset                 asynchronous, active-low reset
//   proc_dep_vld_vec      process blocked on each outgoing channel
//   in_chan_dep_vld_vec   incoming dependence valid per channel
//   in_chan_dep_data_vec  incoming dependence vectors, chan i at [i*PROC_NUM +: PROC_NUM]
//   token_in_vec          report tokens from upstream
//   dl_detect_in          network-wide deadlock already flagged
//   origin                this node originates the token
//   token_clear           drop token forwarding this cycle
//   report_ack            consumer acknowledges the latched report
//   out_chan_dep_vld_vec  outgoing dependence valid
//   out_chan_dep_data     outgoing dependence vector
//   token_out_vec         tokens to downstream (registered)
//   dl_detect_out         confirmed deadlock (combinational)
//   dl_report_vld         latched report pending
//   dl_report_chan        blocked channels at confirmation
//   dl_report_dep         dependence vector at confirmation
//   fsm_state             report FSM state (0 idle, 1 report, 2 hold)
//
// Report handshake: dl_report_vld stays high with dl_report_chan/dep stable
// until a cycle in which report_ack is high; dl_report_vld is low from the
// following cycle. report_ack has no effect while dl_report_vld is low.
module hls_deadlock_monitor_unit #(
   parameter int PROC_NUM       = 4,
   parameter int PROC_ID        = 0,
   parameter int IN_CHAN_NUM    = 2,
   parameter int OUT_CHAN_NUM   = 3,
   parameter int CONFIRM_CYCLES = 1,
   parameter int CNT_W          = 8
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
   input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
   input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
   input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
   input  logic                            dl_detect_in,
   input  logic                            origin,
   input  logic                            token_clear,
   input  logic                            report_ack,
   output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
   output logic [PROC_NUM-1:0]             out_chan_dep_data,
   output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
   output logic                            dl_detect_out,
   output logic                            dl_report_vld,
   output logic [OUT_CHAN_NUM-1:0]         dl_report_chan,
   output logic [PROC_NUM-1:0]             dl_report_dep,
   output logic [1:0]                      fsm_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REPORT = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;
   localparam logic [CNT_W-1:0]    CONF     = CNT_W'(CONFIRM_CYCLES);
   localparam logic [CNT_W-1:0]    CONF_M1  = CNT_W'(CONFIRM_CYCLES - 1);

   state_t               state;
   state_t               state_next;
   logic [PROC_NUM-1:0]  dep_comb;
   logic [PROC_NUM-1:0]  dep;
   logic [PROC_NUM-1:0]  dep_reg;
   logic [CNT_W-1:0]     cnt;
   logic                 gate;
   logic                 blocked;
   logic                 cyc;
   logic                 capture;

   // When a deadlock is already flagged network-wide, dependence updates are
   // only accepted alongside a token; otherwise the last vector is frozen.
   assign gate    = ~dl_detect_in | (|token_in_vec);
   assign blocked = |proc_dep_vld_vec;

   always_comb begin
      dep_comb = '0;
      for (int i = 0; i < IN_CHAN_NUM; i++) begin
         if (in_chan_dep_vld_vec[i]) begin
            dep_comb = dep_comb | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
         end
      end
   end

   assign dep  = gate ? dep_comb : dep_reg;
   assign cyc  = gate & dep[PROC_ID] & blocked;

   assign out_chan_dep_vld_vec = proc_dep_vld_vec;
   assign out_chan_dep_data    = dep_reg | SELF_BIT;

   // cnt counts completed cyc cycles before this one, so the detect fires in
   // the CONFIRM_CYCLES-th consecutive cyc cycle.
   assign dl_detect_out = cyc & (cnt >= CONF_M1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dep_reg       <= '0;
         cnt           <= '0;
         token_out_vec <= '0;
      end else begin
         dep_reg <= blocked ? dep : '0;
         if (!cyc) begin
            cnt <= '0;
         end else if (cnt < CONF) begin
            cnt <= cnt + CNT_W'(1);
         end
         // origin overrides token_clear
         token_out_vec <= (((|token_in_vec) & ~token_clear) | origin) ?
                          proc_dep_vld_vec : '0;
      end
   end

   // Report FSM: IDLE captures on detect, REPORT waits for ack, HOLD swallows
   // the rest of the episode so only one report is raised per deadlock.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (dl_detect_out) begin
               capture    = 1'b1;
               state_next = REPORT;
            end
         end
         REPORT: begin
            if (report_ack) begin
               state_next = cyc ? HOLD : IDLE;
            end
         end
         HOLD: begin
            if (!cyc) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         dl_report_chan <= '0;
         dl_report_dep  <= '0;
      end else begin
         state <= state_next;
         if (capture) begin
            dl_report_chan <= proc_dep_vld_vec;
            dl_report_dep  <= dep;
         end
      end
   end

   assign dl_report_vld = (state == REPORT);
   assign fsm_state     = state;

endmodule

// File: tb/tb_hls_deadlock_monitor_unit.sv
// Testbench for hls_deadlock_monitor_unit. Two instances share all inputs:
// dut with CONFIRM_CYCLES=4 and dut_b with CONFIRM_CYCLES=1. A small
// reference model predicts detect, report state, outgoing data and tokens;
// captured reports are queued when predicted and popped when dl_report_vld
// rises.
module tb_hls_deadlock_monitor_unit;

   localparam int PN   = 4;
   localparam int PID  = 1;
   localparam int INN  = 2;
   localparam int OUTN = 3;
   localparam int CONF = 4;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUT signals ----------------
   logic [OUTN-1:0]   pdv   = '0;
   logic [INN-1:0]    ivld  = '0;
   logic [INN*PN-1:0] idata = '0;
   logic [INN-1:0]    tok   = '0;
   logic              dl_in = 1'b0;
   logic              tclr  = 1'b0;
   logic              org   = 1'b0;
   logic              ack   = 1'b0;

   logic [OUTN-1:0] ocv, ocv_b, otok, otok_b, rchan, rchan_b;
   logic [PN-1:0]   odata, odata_b, rdep, rdep_b;
   logic            odet, odet_b, rvld, rvld_b;
   logic [1:0]      fst, fst_b;

   hls_deadlock_monitor_unit #(
      .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(INN), .OUT_CHAN_NUM(OUTN),
      .CONFIRM_CYCLES(CONF), .CNT_W(8)
   ) dut (
      .clock(clock), .reset(reset),
      .proc_dep_vld_vec(pdv), .in_chan_dep_vld_vec(ivld),
      .in_chan_dep_data_vec(idata), .token_in_vec(tok),
      .dl_detect_in(dl_in), .origin(org), .token_clear(tclr),
      .report_ack(ack),
      .out_chan_dep_vld_vec(ocv), .out_chan_dep_data(odata),
      .token_out_vec(otok), .dl_detect_out(odet),
      .dl_report_vld(rvld), .dl_report_chan(rchan), .dl_report_dep(rdep),
      .fsm_state(fst)
   );

   hls_deadlock_monitor_unit #(
      .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(INN), .OUT_CHAN_NUM(OUTN),
      .CONFIRM_CYCLES(1), .CNT_W(8)
   ) dut_b (
      .clock(clock), .reset(reset),
      .proc_dep_vld_vec(pdv), .in_chan_dep_vld_vec(ivld),
      .in_chan_dep_data_vec(idata), .token_in_vec(tok),
      .dl_detect_in(dl_in), .origin(org), .token_clear(tclr),
      .report_ack(ack),
      .out_chan_dep_vld_vec(ocv_b), .out_chan_dep_data(odata_b),
      .token_out_vec(otok_b), .dl_detect_out(odet_b),
      .dl_report_vld(rvld_b), .dl_report_chan(rchan_b), .dl_report_dep(rdep_b),
      .fsm_state(fst_b)
   );

   // ---------------- model + scoreboard ----------------
   int errors = 0;
   int checks = 0;

   int         cnt_m  = 0;
   int         st_m   = 0;   // 0 idle, 1 report, 2 hold
   logic [3:0] dep_reg_m = '0;
   logic [3:0] dep_m     = '0;
   logic       cyc_m     = 1'b0;
   logic       exp_det   = 1'b0;
   logic       exp_det1  = 1'b0;
   logic [2:0] tok_m     = '0;
   logic [6:0] exp_q[$];

   logic [10:0] obs_vec;
   assign obs_vec = {odet, odet_b, rvld, odata, otok};

   function automatic logic [10:0] exp_vec();
      return {exp_det, exp_det1, (st_m == 1), dep_reg_m | 4'b0010, tok_m};
   endfunction

   // Driver: advance one clock, update the model's registered state with the
   // inputs that were held across the edge, apply new inputs, evaluate the
   // model's combinational terms and return at the falling edge.
   task automatic step(input logic [2:0] p, input logic [1:0] v,
                       input logic [7:0] d, input logic di,
                       input logic [1:0] t, input logic tc,
                       input logic o, input logic a);
      logic       gate;
      logic [3:0] dc;
      @(posedge clock);
      if (reset) begin
         case (st_m)
            0: if (exp_det) st_m = 1;
            1: if (ack) st_m = cyc_m ? 2 : 0;
            default: if (!cyc_m) st_m = 0;
         endcase
         if (!cyc_m) cnt_m = 0;
         else if (cnt_m < CONF) cnt_m = cnt_m + 1;
         dep_reg_m = (|pdv) ? dep_m : 4'b0;
         tok_m = (((|tok) & ~tclr) | org) ? pdv : 3'b0;
      end
      #1;
      pdv = p; ivld = v; idata = d; dl_in = di; tok = t; tclr = tc; org = o; ack = a;
      gate     = ~di | (|t);
      dc       = (v[0] ? d[3:0] : 4'b0) | (v[1] ? d[7:4] : 4'b0);
      dep_m    = gate ? dc : dep_reg_m;
      cyc_m    = gate & dep_m[PID] & (|p);
      exp_det  = cyc_m && (cnt_m >= CONF - 1);
      exp_det1 = cyc_m;
      if (st_m == 0 && exp_det) exp_q.push_back({p, dep_m});
      @(negedge clock);
   endtask

   // Report monitor: on each rising dl_report_vld pop the expected capture.
   logic       vld_q = 1'b0;
   logic [6:0] exp_rep;
   always @(negedge clock) begin
      if (!reset) begin
         vld_q = 1'b0;
      end else begin
         if (rvld && !vld_q) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL report_pop: unexpected report chan=%b dep=%b, none expected",
                        rchan, rdep);
            end else begin
               exp_rep = exp_q.pop_front();
               if ({rchan, rdep} !== exp_rep) begin
                  errors++;
                  $display("FAIL report_data: got chan=%b dep=%b, expected chan=%b dep=%b",
                           rchan, rdep, exp_rep[6:4], exp_rep[3:0]);
               end
            end
         end
         vld_q = rvld;
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #12;
      pdv = 3'b101;
      #1;
      checks++;
      if ({otok, rvld, odata, ocv} !== {3'b000, 1'b0, 4'b0010, 3'b101}) begin
         errors++;
         $display("FAIL reset_outputs: got tok=%b vld=%b data=%b ocv=%b, expected 000 0 0010 101",
                  otok, rvld, odata, ocv);
      end
      pdv = '0;
      @(negedge clock);
      #2 reset = 1'b1;
   endtask

   task automatic test_confirm();
      for (int k = 0; k < 3; k++) step(3'b0, 2'b0, 8'h0, 0, 2'b0, 0, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         // chan 1 carries bit 3 but is not valid: must be masked out
         step(3'b001, 2'b01, 8'b1000_0110, 0, 2'b0, 0, 0, 0);
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL confirm_cycle%0d: got %b expected %b", k, obs_vec, exp_vec());
         end
         if (k == 2) begin
            checks++;
            if (odata !== 4'b0110) begin
               errors++;
               $display("FAIL confirm_dep_latency: got %b expected 0110", odata);
            end
         end
         if (k == 3 || k == 4) begin
            checks++;
            if (odet !== (k == 4)) begin
               errors++;
               $display("FAIL confirm_detect_k%0d: got %b expected %b", k, odet, (k == 4));
            end
         end
         if (k == 1) begin
            checks++;
            if (odet_b !== 1'b1) begin
               errors++;
               $display("FAIL confirm1_first_cycle: got %b expected 1", odet_b);
            end
         end
         if (k == 5) begin
            checks++;
            if ({rvld, rchan, rdep} !== {1'b1, 3'b001, 4'b0110}) begin
               errors++;
               $display("FAIL confirm_report: got vld=%b chan=%b dep=%b expected 1 001 0110",
                        rvld, rchan, rdep);
            end
         end
      end
   endtask

   task automatic test_handshake();
      // ack while the cycle persists, then hold the cycle a while longer
      for (int k = 0; k < 6; k++) begin
         step(3'b001, 2'b01, 8'h06, 0, 2'b0, 0, 0, (k == 0));
         checks++;
         if (obs_vec !== exp_vec() || rvld !== (k == 0)) begin
            errors++;
            $display("FAIL handshake_hold%0d: got %b vld=%b expected %b", k, obs_vec, rvld, exp_vec());
         end
      end
      // one-cycle break ends the episode, then a fresh confirmation
      step(3'b000, 2'b01, 8'h06, 0, 2'b0, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         step(3'b001, 2'b01, 8'h06, 0, 2'b0, 0, 0, 0);
         checks++;
         if (obs_vec !== exp_vec() || rvld !== (k == 5) || odet !== (k >= 4)) begin
            errors++;
            $display("FAIL handshake_new_episode%0d: got %b expected %b", k, obs_vec, exp_vec());
         end
      end
      // ack with the cycle gone: back to idle
      step(3'b000, 2'b00, 8'h00, 0, 2'b0, 0, 0, 1);
      step(3'b000, 2'b00, 8'h00, 0, 2'b0, 0, 0, 0);
      checks++;
      if (rvld !== 1'b0 || fst !== 2'd0) begin
         errors++;
         $display("FAIL handshake_release: got vld=%b state=%0d expected 0 0", rvld, fst);
      end
   endtask

   task automatic test_glitch();
      logic any_det = 1'b0;
      for (int k = 0; k < 7; k++) begin
         // cycle 3 is the gap: inputs invalid, so no self-dependence
         step(3'b001, (k == 3) ? 2'b00 : 2'b01, 8'h06, 0, 2'b0, 0, 0, 0);
         any_det = any_det | odet;
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL glitch_cycle%0d: got %b expected %b", k, obs_vec, exp_vec());
         end
      end
      step(3'b000, 2'b00, 8'h00, 0, 2'b0, 0, 0, 0);
      checks++;
      if (any_det !== 1'b0 || rvld !== 1'b0) begin
         errors++;
         $display("FAIL glitch_reject: got det_seen=%b vld=%b expected 0 0", any_det, rvld);
      end
   endtask

   task automatic test_token();
      step(3'b001, 2'b01, 8'h04, 0, 2'b00, 0, 0, 0);
      step(3'b001, 2'b01, 8'h02, 1, 2'b00, 0, 0, 0);   // frozen: dep stays 0100
      checks++;
      if (odet !== 1'b0 || odata !== 4'b0110 || obs_vec !== exp_vec()) begin
         errors++;
         $display("FAIL token_freeze: got det=%b data=%b expected 0 0110", odet, odata);
      end
      step(3'b101, 2'b01, 8'h08, 1, 2'b10, 0, 0, 0);
      step(3'b101, 2'b01, 8'h08, 1, 2'b10, 1, 0, 0);
      checks++;
      if (otok !== 3'b101) begin
         errors++;
         $display("FAIL token_forward: got %b expected 101", otok);
      end
      step(3'b101, 2'b01, 8'h08, 1, 2'b10, 1, 1, 0);
      checks++;
      if (otok !== 3'b000) begin
         errors++;
         $display("FAIL token_clear: got %b expected 000", otok);
      end
      step(3'b000, 2'b00, 8'h00, 0, 2'b00, 0, 0, 0);
      checks++;
      if (otok !== 3'b101 || obs_vec !== exp_vec()) begin
         errors++;
         $display("FAIL token_origin: got %b expected 101", otok);
      end
      step(3'b000, 2'b00, 8'h00, 0, 2'b00, 0, 0, 0);
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 6; k++) step(3'b011, 2'b10, 8'h20, 0, 2'b00, 0, 1, 0);
      checks++;
      if (rvld !== 1'b1 || otok !== 3'b011) begin
         errors++;
         $display("FAIL reset_mid_setup: got vld=%b tok=%b expected 1 011", rvld, otok);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({otok, rvld, odata} !== {3'b000, 1'b0, 4'b0010}) begin
         errors++;
         $display("FAIL reset_mid: got tok=%b vld=%b data=%b expected 000 0 0010",
                  otok, rvld, odata);
      end
      pdv = '0; ivld = '0; idata = '0; tok = '0; dl_in = 0; tclr = 0; org = 0; ack = 0;
      cnt_m = 0; st_m = 0; dep_reg_m = '0; dep_m = '0; tok_m = '0;
      cyc_m = 0; exp_det = 0; exp_det1 = 0;
      exp_q.delete();
      @(negedge clock);
      #2 reset = 1'b1;
      step(3'b000, 2'b00, 8'h00, 0, 2'b00, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [2:0] p = '0;
      logic [1:0] v = '0;
      logic [7:0] d = '0;
      logic       di = 0;
      logic [1:0] t = '0;
      logic       tc = 0;
      logic       o = 0;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            p  = 3'($urandom_range(0, 7));
            v  = 2'($urandom_range(0, 3));
            d  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) d[1] = 1'b1;
            di = ($urandom_range(0, 7) == 0);
            t  = 2'($urandom_range(0, 3));
            tc = ($urandom_range(0, 1) == 1);
            o  = ($urandom_range(0, 7) == 0);
         end
         step(p, v, d, di, t, tc, o, ($urandom_range(0, 3) == 0));
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random_cycle%0d: got %b expected %b", k, obs_vec, exp_vec());
         end
      end
      for (int k = 0; k < 4; k++) step(3'b000, 2'b00, 8'h00, 0, 2'b00, 0, 0, 1);
      checks++;
      if (exp_q.size() != 0 || rvld !== 1'b0) begin
         errors++;
         $display("FAIL random_drain: got %0d pending vld=%b expected 0 0", exp_q.size(), rvld);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_confirm();
      test_handshake();
      test_glitch();
      test_token();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
